// File: rtl/contador_mais_menos_param.sv
// Up/down counter with limits, clamped load, edge-triggered steps and held-input auto-repeat.
// Define CONTADOR_WRAP_EN to wrap at the limits instead of saturating.
module contador_mais_menos_param #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned MIN    = 0,
    parameter int unsigned MAX    = 15,
    parameter int unsigned STEP   = 1,
    parameter int unsigned REPEAT = 8
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] D,
    input  logic             enp,
    input  logic             soma,
    input  logic             sub,
    output logic [WIDTH-1:0] Q,
    output logic             rco,
    output logic             at_max,
    output logic             at_min,
    output logic             mudou
);

    localparam int unsigned RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    localparam logic [WIDTH:0]   L_MIN_X  = (WIDTH+1)'(MIN);
    localparam logic [WIDTH:0]   L_MAX_X  = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0]   L_STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] L_MIN    = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] L_MAX    = WIDTH'(MAX);
    localparam logic [RW-1:0]    RPT_LAST = (REPEAT > 0) ? RW'(REPEAT - 1) : '0;

    typedef enum logic [1:0] {
        DirNone,
        DirUp,
        DirDown
    } dir_t;

    logic [WIDTH-1:0] r_q, w_q_d;
    logic             r_mudou, w_mudou_d;
    logic             r_soma_q, r_sub_q;
    logic [RW-1:0]    r_rpt, w_rpt_d;
    dir_t             r_dir, w_dir_d;

    logic             w_up_req, w_dn_req;
    logic             w_up_rise, w_dn_rise;
    logic             w_held_up, w_held_dn;
    logic             w_tick;
    logic             w_do_up, w_do_dn;
    logic [WIDTH:0]   w_d_x, w_q_x, w_sum, w_diff;
    logic             w_ovf, w_unf;

    always_comb begin
        w_up_req  = soma & ~sub;
        w_dn_req  = sub & ~soma;
        w_up_rise = w_up_req & ~r_soma_q;
        w_dn_rise = w_dn_req & ~r_sub_q;
        // Auto-repeat only continues a direction that was started by a counted edge
        w_held_up = w_up_req & ~w_up_rise & (r_dir == DirUp);
        w_held_dn = w_dn_req & ~w_dn_rise & (r_dir == DirDown);
        w_tick    = (REPEAT != 0) && enp && (w_held_up || w_held_dn) && (r_rpt == RPT_LAST);
        w_do_up   = enp & (w_up_rise | (w_tick & w_held_up));
        w_do_dn   = enp & (w_dn_rise | (w_tick & w_held_dn));

        w_d_x  = {1'b0, D};
        w_q_x  = {1'b0, r_q};
        w_sum  = w_q_x + L_STEP_X;
        w_diff = w_q_x - L_STEP_X;
        w_ovf  = w_sum > L_MAX_X;
        w_unf  = w_q_x < (L_MIN_X + L_STEP_X);
    end

    always_comb begin
        w_q_d   = r_q;
        w_rpt_d = r_rpt;
        w_dir_d = r_dir;

        if (!ld) begin
            if (w_d_x < L_MIN_X) begin
                w_q_d = L_MIN;
            end else if (w_d_x > L_MAX_X) begin
                w_q_d = L_MAX;
            end else begin
                w_q_d = D;
            end
            w_rpt_d = '0;
            w_dir_d = DirNone;
        end else begin
            if (w_do_up) begin
                if (w_ovf) begin
`ifdef CONTADOR_WRAP_EN
                    w_q_d = L_MIN;
`else
                    w_q_d = L_MAX;
`endif
                end else begin
                    w_q_d = w_sum[WIDTH-1:0];
                end
            end else if (w_do_dn) begin
                if (w_unf) begin
`ifdef CONTADOR_WRAP_EN
                    w_q_d = L_MAX;
`else
                    w_q_d = L_MIN;
`endif
                end else begin
                    w_q_d = w_diff[WIDTH-1:0];
                end
            end

            if (!enp || w_tick || !(w_held_up || w_held_dn)) begin
                w_rpt_d = '0;
            end else begin
                w_rpt_d = r_rpt + 1'b1;
            end

            if (enp && w_up_rise) begin
                w_dir_d = DirUp;
            end else if (enp && w_dn_rise) begin
                w_dir_d = DirDown;
            end else if (!(w_up_req && r_dir == DirUp) && !(w_dn_req && r_dir == DirDown)) begin
                w_dir_d = DirNone;
            end
        end

        w_mudou_d = (w_q_d != r_q);
    end

    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            r_q      <= L_MIN;
            r_mudou  <= 1'b0;
            r_soma_q <= 1'b0;
            r_sub_q  <= 1'b0;
            r_rpt    <= '0;
            r_dir    <= DirNone;
        end else begin
            r_q      <= w_q_d;
            r_mudou  <= w_mudou_d;
            r_soma_q <= soma;
            r_sub_q  <= sub;
            r_rpt    <= w_rpt_d;
            r_dir    <= w_dir_d;
        end
    end

    assign Q      = r_q;
    assign mudou  = r_mudou;
    assign at_max = (r_q == L_MAX);
    assign at_min = (r_q == L_MIN);
    assign rco    = enp & at_min;

endmodule

// File: tb/tb_contador_mais_menos_param.sv
// Directed bench for contador_mais_menos_param: defaults, narrowed limits and STEP=4 instances.
module tb_contador_mais_menos_param;

`ifdef CONTADOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       clr, ld, enp, soma, sub;
    logic [3:0] D;

    logic [3:0] q0, q1, q2;
    logic       rco0, rco1, rco2, amax0, amax1, amax2, amin0, amin1, amin2, m0, m1, m2;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clock = ~clock;

    contador_mais_menos_param u_def (
        .clock(clock), .clr(clr), .ld(ld), .D(D), .enp(enp), .soma(soma), .sub(sub),
        .Q(q0), .rco(rco0), .at_max(amax0), .at_min(amin0), .mudou(m0)
    );

    contador_mais_menos_param #(.MIN(2), .MAX(12)) u_lim (
        .clock(clock), .clr(clr), .ld(ld), .D(D), .enp(enp), .soma(soma), .sub(sub),
        .Q(q1), .rco(rco1), .at_max(amax1), .at_min(amin1), .mudou(m1)
    );

    contador_mais_menos_param #(.STEP(4)) u_st4 (
        .clock(clock), .clr(clr), .ld(ld), .D(D), .enp(enp), .soma(soma), .sub(sub),
        .Q(q2), .rco(rco2), .at_max(amax2), .at_min(amin2), .mudou(m2)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [3:0] val);
        ld = 1'b0;
        D  = val;
        step();
        ld = 1'b1;
    endtask

    task automatic test_reset();
        clr = 1'b0; ld = 1'b1; enp = 1'b0; soma = 1'b0; sub = 1'b0; D = '0;
        step();
        step();
        n_total++; if (q0 !== 4'd0) $display("FAIL rst_q: Q=%0d required 0", q0); else n_pass++;
        n_total++; if (m0 !== 1'b0) $display("FAIL rst_mudou: %b required 0", m0); else n_pass++;
        n_total++; if (amin0 !== 1'b1) $display("FAIL rst_at_min: %b required 1", amin0); else n_pass++;
        n_total++; if (rco0 !== 1'b0) $display("FAIL rst_rco_off: %b required 0", rco0); else n_pass++;
        n_total++; if (q1 !== 4'd2) $display("FAIL rst_q_lim: Q=%0d required 2", q1); else n_pass++;
        enp = 1'b1;
        #1;
        n_total++; if (rco0 !== 1'b1) $display("FAIL rst_rco_on: %b required 1", rco0); else n_pass++;
        #2 clr = 1'b1;
        step();
    endtask

    task automatic test_load_clamp();
        load(4'd3);
        n_total++; if (q1 !== 4'd3) $display("FAIL ld3_lim: Q=%0d required 3", q1); else n_pass++;
        n_total++; if (q0 !== 4'd3) $display("FAIL ld3_def: Q=%0d required 3", q0); else n_pass++;
        n_total++; if (m1 !== 1'b1) $display("FAIL ld3_mudou: %b required 1", m1); else n_pass++;
        load(4'd14);
        n_total++; if (q1 !== 4'd12) $display("FAIL ld14_lim: Q=%0d required 12", q1); else n_pass++;
        n_total++; if (amax1 !== 1'b1) $display("FAIL ld14_at_max: %b required 1", amax1); else n_pass++;
        n_total++; if (q0 !== 4'd14) $display("FAIL ld14_def: Q=%0d required 14", q0); else n_pass++;
        load(4'd0);
        n_total++; if (q1 !== 4'd2) $display("FAIL ld0_lim: Q=%0d required 2", q1); else n_pass++;
        n_total++; if (amin1 !== 1'b1) $display("FAIL ld0_at_min: %b required 1", amin1); else n_pass++;
        n_total++; if (q0 !== 4'd0) $display("FAIL ld0_def: Q=%0d required 0", q0); else n_pass++;
    endtask

    task automatic test_auto_repeat();
        soma = 1'b1;
        step();
        n_total++; if (q0 !== 4'd1) $display("FAIL rpt_edge: Q=%0d required 1", q0); else n_pass++;
        n_total++; if (m0 !== 1'b1) $display("FAIL rpt_edge_mudou: %b required 1", m0); else n_pass++;
        repeat (7) step();
        n_total++; if (q0 !== 4'd1) $display("FAIL rpt_plus7: Q=%0d required 1", q0); else n_pass++;
        n_total++; if (m0 !== 1'b0) $display("FAIL rpt_plus7_mudou: %b required 0", m0); else n_pass++;
        step();
        n_total++; if (q0 !== 4'd2) $display("FAIL rpt_plus8: Q=%0d required 2", q0); else n_pass++;
        repeat (8) step();
        n_total++; if (q0 !== 4'd3) $display("FAIL rpt_plus16: Q=%0d required 3", q0); else n_pass++;
        n_total++; if (q2 !== 4'd12) $display("FAIL rpt_step4: Q=%0d required 12", q2); else n_pass++;
        n_total++; if (q1 !== 4'd5) $display("FAIL rpt_lim: Q=%0d required 5", q1); else n_pass++;
        repeat (3) step();
        n_total++; if (q0 !== 4'd3) $display("FAIL rpt_plus19: Q=%0d required 3", q0); else n_pass++;
        soma = 1'b0;
        step();
    endtask

    task automatic test_enp_lost();
        enp  = 1'b0;
        soma = 1'b1;
        step();
        n_total++; if (q0 !== 4'd3) $display("FAIL enp0_hold: Q=%0d required 3", q0); else n_pass++;
        enp = 1'b1;
        step();
        n_total++; if (q0 !== 4'd3) $display("FAIL enp_no_defer: Q=%0d required 3", q0); else n_pass++;
        n_total++; if (m0 !== 1'b0) $display("FAIL enp_no_defer_mudou: %b required 0", m0); else n_pass++;
        soma = 1'b0;
        step();
    endtask

    task automatic test_limit();
        load(4'd15);
        n_total++; if (amax0 !== 1'b1) $display("FAIL lim_at_max: %b required 1", amax0); else n_pass++;
        soma = 1'b1;
        step();
        n_total++; if (q0 !== (WRAP ? 4'd0 : 4'd15)) $display("FAIL ovf_q: Q=%0d required %0d", q0, WRAP ? 0 : 15); else n_pass++;
        n_total++; if (m0 !== WRAP) $display("FAIL ovf_mudou: %b required %b", m0, WRAP); else n_pass++;
        n_total++; if (q1 !== (WRAP ? 4'd2 : 4'd12)) $display("FAIL ovf_lim: Q=%0d required %0d", q1, WRAP ? 2 : 12); else n_pass++;
        n_total++; if (q2 !== (WRAP ? 4'd0 : 4'd15)) $display("FAIL ovf_step4: Q=%0d required %0d", q2, WRAP ? 0 : 15); else n_pass++;
        soma = 1'b0;
        step();
        n_total++; if (m0 !== 1'b0) $display("FAIL ovf_mudou_clear: %b required 0", m0); else n_pass++;
    endtask

    task automatic test_step_sat();
        load(4'd2);
        sub = 1'b1;
        step();
        n_total++; if (q2 !== (WRAP ? 4'd15 : 4'd0)) $display("FAIL unf_step4: Q=%0d required %0d", q2, WRAP ? 15 : 0); else n_pass++;
        n_total++; if (m2 !== 1'b1) $display("FAIL unf_step4_mudou: %b required 1", m2); else n_pass++;
        n_total++; if (q0 !== 4'd1) $display("FAIL down_def: Q=%0d required 1", q0); else n_pass++;
        n_total++; if (q1 !== (WRAP ? 4'd12 : 4'd2)) $display("FAIL unf_lim: Q=%0d required %0d", q1, WRAP ? 12 : 2); else n_pass++;
        sub = 1'b0;
        step();
    endtask

    task automatic test_both();
        load(4'd6);
        soma = 1'b1;
        sub  = 1'b1;
        step();
        n_total++; if (q0 !== 4'd6) $display("FAIL both_q: Q=%0d required 6", q0); else n_pass++;
        n_total++; if (m0 !== 1'b0) $display("FAIL both_mudou: %b required 0", m0); else n_pass++;
        n_total++; if (q2 !== 4'd6) $display("FAIL both_step4: Q=%0d required 6", q2); else n_pass++;
        soma = 1'b0;
        sub  = 1'b0;
        step();
        sub = 1'b1;
        step();
        n_total++; if (q0 !== 4'd5) $display("FAIL down_6: Q=%0d required 5", q0); else n_pass++;
        n_total++; if (q2 !== 4'd2) $display("FAIL down_step4: Q=%0d required 2", q2); else n_pass++;
        sub = 1'b0;
        step();
    endtask

    task automatic test_clr_mid();
        soma = 1'b1;
        step();
        n_total++; if (q0 !== 4'd6) $display("FAIL pre_clr: Q=%0d required 6", q0); else n_pass++;
        clr = 1'b0;
        #1;
        n_total++; if (q0 !== 4'd0) $display("FAIL clr_async_q: Q=%0d required 0", q0); else n_pass++;
        n_total++; if (m0 !== 1'b0) $display("FAIL clr_async_mudou: %b required 0", m0); else n_pass++;
        n_total++; if (rco0 !== 1'b1) $display("FAIL clr_rco: %b required 1", rco0); else n_pass++;
        n_total++; if (q1 !== 4'd2) $display("FAIL clr_lim: Q=%0d required 2", q1); else n_pass++;
        #2 clr = 1'b1;
        step();
        n_total++; if (q0 !== 4'd1) $display("FAIL clr_release_edge: Q=%0d required 1", q0); else n_pass++;
        soma = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_load_clamp();
        test_auto_repeat();
        test_enp_lost();
        test_limit();
        test_step_sat();
        test_both();
        test_clr_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/contador_mais_menos_param.md
CONTADOR_MAIS_MENOS_PARAM -- requirements
Module: contador_mais_menos_param

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (2..16).
REQ-002 Parameter MIN, default 0, lower count limit; MIN < MAX <= 2**WIDTH-1.
REQ-003 Parameter MAX, default 15, upper count limit.
REQ-004 Parameter STEP, default 1, increment/decrement magnitude (1..MAX-MIN).
REQ-005 Parameter REPEAT, default 8, held-input auto-repeat period in enabled cycles; 0 disables auto-repeat.
REQ-006 clock  input  1  single clock, all state updates on rising edge.
REQ-007 clr  input  1  reset, asynchronous, active-low.
REQ-008 ld  input  1  synchronous load, active-low.
REQ-009 D  input  WIDTH  load value.
REQ-010 enp  input  1  count enable, active-high.
REQ-011 soma  input  1  count-up request, level (e.g. button).
REQ-012 sub  input  1  count-down request, level.
REQ-013 Q  output  WIDTH  registered count value.
REQ-014 rco  output  1  combinational; 1 when enp=1 and Q==MIN.
REQ-015 at_max  output  1  combinational; 1 when Q==MAX.
REQ-016 at_min  output  1  combinational; 1 when Q==MIN.
REQ-017 mudou  output  1  registered one-cycle pulse, 1 in the cycle after any change of Q by count or load.

Function
REQ-018 Priority per edge: clr (async) > ld=0 > counting > hold.
REQ-019 ld=0 loads D clamped: D<MIN gives MIN, D>MAX gives MAX; ld=0 also clears repeat counter and direction state.
REQ-020 Edge registers soma_q/sub_q sample soma/sub every cycle regardless of enp or ld.
REQ-021 Up step when enp=1, soma=1, sub=0 and either soma rising (soma=1, soma_q=0) or repeat tick.
REQ-022 Down step symmetric with sub, soma swapped.
REQ-023 soma=1 and sub=1 together: no step, repeat counter cleared, Q held.
REQ-024 Repeat counter: clears on a rising edge or when the held direction drops or enp=0; otherwise increments each enabled cycle; tick when count reaches REPEAT-1, then clears; REPEAT=0 never ticks.
REQ-025 First step occurs in the cycle of the rising edge; with default REPEAT=8 a held input steps again every 8 enabled cycles.
REQ-026 Arithmetic in WIDTH+1 bits; up: Q+STEP>MAX is overflow; down: Q<MIN+STEP is underflow.
REQ-027 Overflow/underflow handling per Configuration section; otherwise Q takes Q±STEP.
REQ-028 Step attempted at limit with saturation: Q unchanged, mudou stays 0.
REQ-029 Rising edge while enp=0 is lost; no deferred step.

Reset
REQ-030 clr=0 forces immediately: Q=MIN, mudou=0, soma_q=0, sub_q=0, repeat counter=0.
REQ-031 clr deassertion mid-hold: held soma/sub seen as new rising edge on first enabled cycle after release.

Configuration
REQ-032 Macro CONTADOR_WRAP_EN defined: overflow sets Q=MIN, underflow sets Q=MAX (exact limit, not modular remainder), mudou pulses.
REQ-033 Macro undefined: overflow saturates at MAX, underflow at MIN.

Verification
REQ-034 Defaults, clr pulse mid-count -> Q=0 asynchronously, mudou=0, rco=1 when enp=1.
REQ-035 ld=0, D=3 with MIN=2,MAX=12 -> Q=3; D=14 -> Q=12, at_max=1; D=0 -> Q=2, at_min=1.
REQ-036 enp=1, soma held 20 cycles from Q=0, REPEAT=8 -> Q=1 at edge, 2 at +8, 3 at +16.
REQ-037 Q=15, soma pulse: without macro Q=15, mudou=0; with CONTADOR_WRAP_EN Q=0, mudou=1.
REQ-038 STEP=4, Q=2, sub pulse -> Q=0 saturated (Q=15 with wrap); soma+sub together -> Q unchanged.
